mem_access_ctrl: RTL and testbench

//  Registered MEM-stage access controller sitting directly upstream of the combinational data memory.

---
 rtl/mem_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Registered MEM-stage load/store controller in front of a combinational data memory.
// Optional build macro MEM_ACC_PERF_EN adds saturating load/store performance counters.
module mem_access_ctrl #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_wen,
    output logic        mem_ren,
    output logic [31:0] mem_adress,
    output logic [31:0] mem_dataw,
    input  logic [31:0] mem_datar
`ifdef MEM_ACC_PERF_EN
    ,
    output logic [15:0] perf_loads,
    output logic [15:0] perf_stores
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RSP  = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        mem_wen_q, mem_wen_d;
    logic        mem_ren_q, mem_ren_d;
    logic [31:0] mem_adress_q, mem_adress_d;
    logic [31:0] mem_dataw_q, mem_dataw_d;

    logic [31:0] word_idx;
    logic        req_err;
    logic        sub_word_store;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Request checks run on the latched copy, one cycle after acceptance.
    always_comb begin
        word_idx       = {2'b00, addr_q[31:2]};
        sub_word_store = we_q && (size_q != SZ_WORD);
        req_err        = 1'b0;
        if (size_q == SZ_RSVD) begin
            req_err = 1'b1;
        end
        if ((size_q == SZ_HALF) && addr_q[0]) begin
            req_err = 1'b1;
        end
        if ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
        if (word_idx >= 32'(MEM_WORDS)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        shifted = mem_datar >> {addr_q[1:0], 3'b000};
        case (size_q)
            SZ_BYTE: load_ext = uns_q ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_ext = uns_q ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = mem_datar;
        endcase
    end

    // Read-modify-write merge: only the addressed little-endian lanes take store data.
    always_comb begin
        merged = mem_datar;
        if (size_q == SZ_BYTE) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == SZ_HALF) begin
            if (addr_q[1]) begin
                merged[31:16] = wdata_q[15:0];
            end else begin
                merged[15:0] = wdata_q[15:0];
            end
        end else begin
            merged = wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    if (req_err) begin
                        state_d = RSP;
                    end else if (we_q && !sub_word_store) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = we_q ? WR : RSP;
            WR:      state_d = RSP;
            RSP:     state_d = rsp_ready ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
    end

    // Every port is a flop; this block computes the value each takes on the next edge.
    always_comb begin
        pend_d       = pend_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        mem_wen_d    = 1'b0;
        mem_ren_d    = 1'b0;
        mem_adress_d = mem_adress_q;
        mem_dataw_d  = mem_dataw_q;
        case (state_q)
            IDLE: begin
                if (!pend_q) begin
                    req_ready_d = 1'b1;
                    if (req_valid && req_ready_q) begin
                        req_ready_d = 1'b0;
                        pend_d      = 1'b1;
                        we_d        = req_we;
                        size_d      = req_size;
                        uns_d       = req_unsigned;
                        addr_d      = req_addr;
                        wdata_d     = req_wdata;
                    end
                end else begin
                    pend_d = 1'b0;
                    if (req_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'h0;
                    end else begin
                        mem_adress_d = word_idx;
                        if (we_q && !sub_word_store) begin
                            mem_wen_d   = 1'b1;
                            mem_dataw_d = wdata_q;
                        end else begin
                            mem_ren_d = 1'b1;
                        end
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    mem_wen_d   = 1'b1;
                    mem_dataw_d = merged;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = load_ext;
                end
            end
            WR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = 32'h0;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

`ifdef MEM_ACC_PERF_EN
    logic [15:0] perf_loads_q, perf_loads_d;
    logic [15:0] perf_stores_q, perf_stores_d;

    always_comb begin
        perf_loads_d  = perf_loads_q;
        perf_stores_d = perf_stores_q;
        if ((state_q == RSP) && rsp_ready && !rsp_err_q) begin
            if (we_q) begin
                if (perf_stores_q != 16'hFFFF) perf_stores_d = perf_stores_q + 16'd1;
            end else begin
                if (perf_loads_q != 16'hFFFF) perf_loads_d = perf_loads_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_loads_q  <= 16'h0;
            perf_stores_q <= 16'h0;
        end else begin
            perf_loads_q  <= perf_loads_d;
            perf_stores_q <= perf_stores_d;
        end
    end

    assign perf_loads  = perf_loads_q;
    assign perf_stores = perf_stores_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_q       <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'h0;
            rsp_err_q    <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_ren_q    <= 1'b0;
            mem_adress_q <= 32'h0;
            mem_dataw_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
            mem_wen_q    <= mem_wen_d;
            mem_ren_q    <= mem_ren_d;
            mem_adress_q <= mem_adress_d;
            mem_dataw_q  <= mem_dataw_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_err    = rsp_err_q;
    assign mem_wen    = mem_wen_q;
    assign mem_ren    = mem_ren_q;
    assign mem_adress = mem_adress_q;
    assign mem_dataw  = mem_dataw_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: behavioural memory model, random and directed traffic.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_adress;
    logic [31:0] mem_dataw;
    logic [31:0] mem_datar;
`ifdef MEM_ACC_PERF_EN
    logic [15:0] perf_loads;
    logic [15:0] perf_stores;
`endif

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_wen(mem_wen),
        .mem_ren(mem_ren), .mem_adress(mem_adress), .mem_dataw(mem_dataw),
        .mem_datar(mem_datar)
`ifdef MEM_ACC_PERF_EN
        , .perf_loads(perf_loads), .perf_stores(perf_stores)
`endif
    );

    logic [31:0] dut_mem [0:255];
    logic [31:0] ref_mem [0:255];

    assign mem_datar = (mem_ren && !mem_wen && (mem_adress < 32'd256)) ? dut_mem[mem_adress[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (mem_wen && !mem_ren && (mem_adress < 32'd256)) dut_mem[mem_adress[7:0]] <= mem_dataw;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        we;
        int          ren;
        int          wen;
        int          lat;
        logic [31:0] idx;
        logic [31:0] wword;
        int          ren_base;
        int          wen_base;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ren_total = 0;
    int wen_total = 0;
    int exp_loads = 0;
    int exp_stores = 0;
    int first_cyc = 0;
    logic [31:0] first_rdata = 32'h0;
    logic first_err = 1'b0;
    logic valid_prev = 1'b0;
    bit hold_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h at t=%0t", name, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: strobe accounting, response stability and scoreboard pops.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            checkOutput("strobe_overlap", {31'b0, mem_wen & mem_ren}, 32'h0);
            if (mem_ren) ren_total++;
            if (mem_wen) wen_total++;
            if (mem_ren || mem_wen) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL stray_strobe: got strobe with no transaction, want none");
                end else begin
                    checkOutput("mem_adress", mem_adress, sb[0].idx);
                    if (mem_wen) checkOutput("mem_dataw", mem_dataw, sb[0].wword);
                end
            end
            if (rsp_valid && !valid_prev) begin
                first_cyc   = cyc;
                first_rdata = rsp_rdata;
                first_err   = rsp_err;
            end else if (rsp_valid) begin
                checkOutput("rdata_stable", rsp_rdata, first_rdata);
                checkOutput("err_stable", {31'b0, rsp_err}, {31'b0, first_err});
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: got response, want none");
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                    checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    checkOutput("latency", 32'(first_cyc - e.acc_cyc), 32'(e.lat));
                    checkOutput("ren_count", 32'(ren_total - e.ren_base), 32'(e.ren));
                    checkOutput("wen_count", 32'(wen_total - e.wen_base), 32'(e.wen));
                    if (!e.err) begin
                        if (e.we) exp_stores++;
                        else exp_loads++;
                    end
                end
            end
            valid_prev = rsp_valid;
        end else begin
            valid_prev = 1'b0;
        end
    end

    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int n;
        logic [31:0] w, sh, mask, nw;
        int bsh;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size;
        req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("[TB] FAIL accept_timeout: got req_ready=0, want 1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.acc_cyc = cyc; e.ren_base = ren_total; e.wen_base = wen_total;
        e.we = we; e.idx = addr / 4; e.rdata = 32'h0; e.wword = 32'h0;
        e.err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= 256);
        if (e.err) begin
            e.ren = 0; e.wen = 0; e.lat = 1;
        end else if (!we) begin
            w = ref_mem[e.idx[7:0]];
            sh = w >> (8 * (addr % 4));
            e.ren = 1; e.wen = 0; e.lat = 2;
            if (size == 2'd0) e.rdata = (!uns && sh[7]) ? ((sh & 32'hFF) | 32'hFFFFFF00) : (sh & 32'hFF);
            else if (size == 2'd1) e.rdata = (!uns && sh[15]) ? ((sh & 32'hFFFF) | 32'hFFFF0000) : (sh & 32'hFFFF);
            else e.rdata = w;
        end else begin
            w = ref_mem[e.idx[7:0]];
            e.wen = 1;
            if (size == 2'd2) begin
                nw = wdata; e.ren = 0; e.lat = 2;
            end else begin
                bsh  = (size == 2'd0) ? 8 * (addr % 4) : 16 * ((addr / 2) % 2);
                mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << bsh;
                nw   = (w & ~mask) | ((wdata << bsh) & mask);
                e.ren = 1; e.lat = 3;
            end
            e.wword = nw;
            ref_mem[e.idx[7:0]] = nw;
        end
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++; errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic [31:0] saved;
        for (int i = 0; i < 256; i++) begin
            dut_mem[i] = $urandom;
            ref_mem[i] = dut_mem[i];
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", {31'b0, req_ready}, 32'h0);
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
        checkOutput("reset_strobes", {30'b0, mem_wen, mem_ren}, 32'h0);
        checkOutput("reset_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_adress", mem_adress, 32'h0);
        checkOutput("reset_dataw", mem_dataw, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("idle_req_ready", {31'b0, req_ready}, 32'h1);

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h20, 32'h80010000);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h22, 32'h0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h23, 32'h0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h400, 32'h0);
        applyStimulus(1'b0, 2'd3, 1'b0, 32'h0, 32'h0);
        drain();

        // Back-pressure: response held while new requests are refused.
        hold_ready = 1'b1;
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'h12345678;
            @(negedge clk);
            checkOutput("hold_req_ready", {31'b0, req_ready}, 32'h0);
            checkOutput("hold_rsp_valid", {31'b0, rsp_valid}, 32'h1);
        end
        req_valid = 1'b0;
        hold_ready = 1'b0;
        drain();

        // Reset during the WR cycle of a word store.
        saved = ref_mem[12];
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h30, 32'hCAFEF00D);
        ref_mem[12] = saved;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_wen && n < 20);
        checkOutput("wen_before_reset", {31'b0, mem_wen}, 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_drops_wen", {31'b0, mem_wen}, 32'h0);
        checkOutput("reset_drops_ren", {31'b0, mem_ren}, 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        checkOutput("midreset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("post_reset_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("post_reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
`ifdef MEM_ACC_PERF_EN
        exp_loads = 0;
        exp_stores = 0;
`endif
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        drain();

        for (int i = 0; i < 200; i++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 1100)), $urandom);
        end
        drain();

`ifdef MEM_ACC_PERF_EN
        checkOutput("perf_loads", {16'h0, perf_loads}, 32'(exp_loads));
        checkOutput("perf_stores", {16'h0, perf_stores}, 32'(exp_stores));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
